// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl: performs a WIDTH*WORDS-bit add by running one external
// WIDTH-bit adder slice once per cycle, carry chained from LSB to MSB.
// Operands are accepted and results returned over valid/ready handshakes.
module adder_seq_ctrl #(
    parameter  int WIDTH = 8,
    parameter  int WORDS = 4,
    localparam int N     = WIDTH * WORDS,
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    // request side
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [N-1:0]     op_a,
    input  logic [N-1:0]     op_b,
    input  logic             op_cin,
    // response side
    output logic             res_valid,
    input  logic             res_ready,
    output logic [N-1:0]     res_sum,
    output logic             res_cout,
    output logic             busy,
    // shared adder slice
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_reg;
    state_t             state_next;
    logic [IDX_W-1:0]   idx_reg;
    logic               carry_reg;
    logic [N-1:0]       op_a_reg;
    logic [N-1:0]       op_b_reg;
    logic [N-1:0]       res_sum_reg;
    logic               res_cout_reg;

    logic               accept;
    logic               last_slice;
    logic [WIDTH-1:0]   a_slices [WORDS];
    logic [WIDTH-1:0]   b_slices [WORDS];

    // Split the latched operands into per-slice views so the active slice
    // can be picked with a plain array index.
    for (genvar gi = 0; gi < WORDS; gi++) begin : g_slice
        assign a_slices[gi] = op_a_reg[gi*WIDTH +: WIDTH];
        assign b_slices[gi] = op_b_reg[gi*WIDTH +: WIDTH];
    end

    assign accept     = start_valid && (state_reg == IDLE);
    assign last_slice = (idx_reg == IDX_W'(WORDS - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode and handshake / adder-drive outputs.
    always_comb begin
        state_next  = state_reg;
        start_ready = 1'b0;
        res_valid   = 1'b0;
        busy        = 1'b0;
        add_a       = '0;
        add_b       = '0;
        add_cin     = 1'b0;
        case (state_reg)
            IDLE: begin
                start_ready = 1'b1;
                if (start_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy    = 1'b1;
                add_a   = a_slices[idx_reg];
                add_b   = b_slices[idx_reg];
                add_cin = carry_reg;
                if (last_slice) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                res_valid = 1'b1;
                // idx and carry are frozen on the last slice, so the adder
                // keeps seeing the inputs of the final slice.
                add_a     = a_slices[idx_reg];
                add_b     = b_slices[idx_reg];
                add_cin   = carry_reg;
                if (res_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand capture, slice sequencing and result accumulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_reg      <= '0;
            carry_reg    <= 1'b0;
            op_a_reg     <= '0;
            op_b_reg     <= '0;
            res_sum_reg  <= '0;
            res_cout_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        op_a_reg     <= op_a;
                        op_b_reg     <= op_b;
                        carry_reg    <= op_cin;
                        idx_reg      <= '0;
                        res_sum_reg  <= '0;
                        res_cout_reg <= 1'b0;
                    end
                end
                RUN: begin
                    for (int i = 0; i < WORDS; i++) begin
                        if (idx_reg == IDX_W'(i)) begin
                            res_sum_reg[i*WIDTH +: WIDTH] <= add_sum;
                        end
                    end
                    if (last_slice) begin
                        // Carry-out of the top slice is the result carry;
                        // idx and carry stay put so the adder inputs hold.
                        res_cout_reg <= add_cout;
                    end else begin
                        carry_reg <= add_cout;
                        idx_reg   <= idx_reg + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign res_sum  = res_sum_reg;
    assign res_cout = res_cout_reg;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Testbench for adder_seq_ctrl: models the external adder slice, runs a
// table of directed vectors, hand-written multi-cycle corner cases and
// random operations checked against a whole-word arithmetic reference.
module tb_adder_seq_ctrl;

    localparam int WIDTH = 8;
    localparam int WORDS = 4;
    localparam int N     = WIDTH * WORDS;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start_valid = 1'b0;
    logic             start_ready;
    logic [N-1:0]     op_a = '0;
    logic [N-1:0]     op_b = '0;
    logic             op_cin = 1'b0;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [N-1:0]     res_sum;
    logic             res_cout;
    logic             busy;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic [WIDTH:0]   add_full;

    int total = 0;
    int bad   = 0;

    adder_seq_ctrl #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .op_cin      (op_cin),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_sum     (res_sum),
        .res_cout    (res_cout),
        .busy        (busy),
        .add_a       (add_a),
        .add_b       (add_b),
        .add_cin     (add_cin),
        .add_sum     (add_sum),
        .add_cout    (add_cout)
    );

    always #5 clk = ~clk;

    // The shared adder slice: purely combinational.
    assign add_full = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
    assign add_sum  = add_full[WIDTH-1:0];
    assign add_cout = add_full[WIDTH];

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         cin;
        logic [N-1:0] exp_sum;
        logic         exp_cout;
    } vec_t;

    vec_t vecs [8];

    // Whole-word reference: {cout, sum} = A + B + cin.
    function automatic logic [N:0] ref_add(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic c);
        return {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) until res_valid; returns the number of edges waited.
    task automatic wait_valid(output int edges);
        edges = 0;
        while (!res_valid && edges < 50) begin
            tick();
            edges++;
        end
        if (!res_valid) check("res_valid_timeout", 64'(res_valid), 64'd1);
    endtask

    // Full transaction from IDLE: accept, wait for result, handshake.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic c,
                          input string tag);
        logic [N:0] exp;
        logic [N-1:0] got_sum;
        logic got_cout;
        int lat;
        int guard;
        exp = ref_add(a, b, c);
        guard = 0;
        start_valid = 1'b1;
        op_a = a;
        op_b = b;
        op_cin = c;
        while (!start_ready && guard < 50) begin
            tick();
            guard++;
        end
        check({tag, "_start_ready"}, 64'(start_ready), 64'd1);
        tick();                                   // accept edge
        start_valid = 1'b0;
        op_a = $urandom();                        // must not be sampled
        op_b = $urandom();
        op_cin = ~c;
        check({tag, "_cleared"}, 64'(res_sum), 64'd0);
        wait_valid(lat);
        got_sum = res_sum;
        got_cout = res_cout;
        check({tag, "_latency"}, 64'(lat), 64'(WORDS));
        check({tag, "_sum"}, 64'(got_sum), 64'(exp[N-1:0]));
        check({tag, "_cout"}, 64'(got_cout), 64'(exp[N]));
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check({tag, "_idle_ready"}, 64'(start_ready), 64'd1);
        check({tag, "_sum_held"}, 64'(res_sum), 64'(exp[N-1:0]));
        $display("op %s a=%08h b=%08h cin=%0d -> sum=%08h cout=%0d lat=%0d",
                 tag, a, b, c, got_sum, got_cout, lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        logic         rc;
        logic [N:0]   exp2;
        int           lat;

        vecs[0] = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0};
        vecs[1] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1};
        vecs[2] = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0};
        vecs[3] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1};
        vecs[4] = '{32'h12345678, 32'h11111111, 1'b1, 32'h2345678A, 1'b0};
        vecs[5] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0};
        vecs[6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1};
        vecs[7] = '{32'h00FF00FF, 32'h00010001, 1'b0, 32'h01000100, 1'b0};

        // Reset state.
        #12;
        check("rst_start_ready", 64'(start_ready), 64'd1);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_res_sum", 64'(res_sum), 64'd0);
        check("rst_res_cout", 64'(res_cout), 64'd0);
        check("rst_add_a", 64'(add_a), 64'd0);
        check("rst_add_cin", 64'(add_cin), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Directed table, each entry a full transaction.
        for (int i = 0; i < 8; i++) begin
            start_valid = 1'b1;
            op_a = vecs[i].a;
            op_b = vecs[i].b;
            op_cin = vecs[i].cin;
            check("tbl_ready", 64'(start_ready), 64'd1);
            tick();
            start_valid = 1'b0;
            op_a = ~vecs[i].a;
            wait_valid(lat);
            check("tbl_latency", 64'(lat), 64'(WORDS));
            check("tbl_sum", 64'(res_sum), 64'(vecs[i].exp_sum));
            check("tbl_cout", 64'(res_cout), 64'(vecs[i].exp_cout));
            $display("tbl %0d a=%08h b=%08h cin=%0d -> sum=%08h cout=%0d", i,
                     vecs[i].a, vecs[i].b, vecs[i].cin, res_sum, res_cout);
            res_ready = 1'b1;
            tick();
            res_ready = 1'b0;
        end

        // Carry ripples through every slice: add_cin high in each RUN cycle.
        start_valid = 1'b1;
        op_a = 32'hFFFFFFFF;
        op_b = 32'h00000000;
        op_cin = 1'b1;
        tick();
        start_valid = 1'b0;
        op_cin = 1'b0;
        for (int k = 0; k < WORDS; k++) begin
            check("ripple_add_cin", 64'(add_cin), 64'd1);
            check("ripple_add_a", 64'(add_a), 64'hFF);
            check("ripple_busy", 64'(busy), 64'd1);
            tick();
        end
        check("ripple_valid", 64'(res_valid), 64'd1);
        check("ripple_sum", 64'(res_sum), 64'd0);
        check("ripple_cout", 64'(res_cout), 64'd1);
        $display("ripple a=ffffffff b=00000000 cin=1 -> sum=%08h cout=%0d", res_sum, res_cout);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;

        // Stall in DONE with a concurrent request, then back-to-back accept.
        start_valid = 1'b1;
        op_a = 32'h01020304;
        op_b = 32'h10203040;
        op_cin = 1'b0;
        tick();
        op_a = 32'hDEADBEEF;
        op_b = 32'h11111111;
        wait_valid(lat);
        for (int k = 0; k < 5; k++) begin
            op_a = $urandom();
            tick();
            check("stall_valid", 64'(res_valid), 64'd1);
            check("stall_sum", 64'(res_sum), 64'h11223344);
            check("stall_cout", 64'(res_cout), 64'd0);
            check("stall_ready", 64'(start_ready), 64'd0);
        end
        $display("stall sum=%08h held for 5 cycles with start_valid high", res_sum);
        res_ready = 1'b1;
        tick();                                   // DONE handshake edge
        res_ready = 1'b0;
        op_a = 32'hA5A5A5A5;
        op_b = 32'h5A5A5A5B;
        op_cin = 1'b1;
        check("b2b_idle_valid", 64'(res_valid), 64'd0);
        check("b2b_idle_ready", 64'(start_ready), 64'd1);
        check("b2b_idle_busy", 64'(busy), 64'd0);
        check("b2b_idle_sum_held", 64'(res_sum), 64'h11223344);
        tick();                                   // second accept edge
        start_valid = 1'b0;
        op_a = '0;
        check("b2b_accept_busy", 64'(busy), 64'd1);
        check("b2b_accept_cleared", 64'(res_sum), 64'd0);
        wait_valid(lat);
        exp2 = ref_add(32'hA5A5A5A5, 32'h5A5A5A5B, 1'b1);
        check("b2b_latency", 64'(lat), 64'(WORDS));
        check("b2b_sum", 64'(res_sum), 64'(exp2[N-1:0]));
        check("b2b_cout", 64'(res_cout), 64'(exp2[N]));
        $display("b2b a=a5a5a5a5 b=5a5a5a5b cin=1 -> sum=%08h cout=%0d", res_sum, res_cout);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;

        // Reset during RUN aborts the operation.
        start_valid = 1'b1;
        op_a = 32'h01010101;
        op_b = 32'h01010101;
        op_cin = 1'b0;
        tick();
        start_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check("abort_state_ready", 64'(start_ready), 64'd1);
        check("abort_valid", 64'(res_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_sum", 64'(res_sum), 64'd0);
        check("abort_cout", 64'(res_cout), 64'd0);
        check("abort_add_b", 64'(add_b), 64'd0);
        $display("abort reset mid-run -> ready=%0d busy=%0d sum=%08h", start_ready, busy, res_sum);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("abort_post_ready", 64'(start_ready), 64'd1);

        // Random operations against the arithmetic reference.
        for (int i = 0; i < 40; i++) begin
            ra = $urandom();
            rb = $urandom();
            rc = 1'($urandom_range(0, 1));
            if (i % 8 == 0) rb = ~ra;           // stress full carry chains
            run_op(ra, rb, rc, "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
